// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the IF/ID pipeline register layout.
package riscv_pkg;

    localparam int                XLEN               = 32;
    localparam logic [XLEN-1:0]   NOP_INSTR          = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [XLEN-1:0]   DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int                DEFAULT_IMEM_WORDS = 1024;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/program_counter.sv
// Fetch PC register: redirect beats sequential advance, otherwise hold.
module program_counter
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // Natural 32-bit wrap takes 0xFFFFFFFC back to 0.
    assign pc_plus4 = pc + 32'd4;

    // PC update; redirect targets are forced word-aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc & ~32'd3;
        else if (advance)        pc <= pc_plus4;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to imem and holds the IF/ID register.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_out,
    input  logic [XLEN-1:0] instr_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            fetch_fault
);

    localparam int              AW         = XLEN - 2;
    localparam logic [AW-1:0]   IMEM_LIMIT = AW'(IMEM_WORDS);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            advance;
    logic            out_of_range;
    logic            misaligned;
    if_id_t          if_id;

    // A new instruction may enter IF/ID when it is empty or being consumed.
    assign advance      = !if_id.valid || id_ready;
    assign out_of_range = pc[XLEN-1:2] >= IMEM_LIMIT;
    assign misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);

    assign pc_out      = pc;
    assign if_id_valid = if_id.valid;
    assign if_id_instr = if_id.instr;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc4   = if_id.pc4;

    program_counter #(.RESET_PC(RESET_PC)) u_pc (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc             (pc),
        .pc_plus4       (pc_plus4)
    );

    // IF/ID register: redirect flushes to a bubble, advance captures, else stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id <= '{valid: 1'b0, instr: NOP_INSTR, pc: RESET_PC, pc4: RESET_PC + 32'd4};
        end else if (redirect_valid) begin
            if_id.valid <= 1'b0;
        end else if (advance) begin
            if_id <= '{valid: 1'b1,
                       instr: out_of_range ? NOP_INSTR : instr_in,
                       pc:    pc,
                       pc4:   pc_plus4};
        end
    end

    // Sticky fault on misaligned redirect or a fetch beyond the end of imem.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fetch_fault <= 1'b0;
        else if (misaligned || (!redirect_valid && advance && out_of_range))
            fetch_fault <= 1'b1;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios then random traffic.
module tb_instruction_fetch;

    localparam int          WORDS = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_fault;

    logic [31:0] mem [WORDS];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } item_t;

    // Reference model: the instruction waiting for decode, the next fetch
    // address and the sticky fault flag.
    item_t       q[$];
    logic [31:0] mpc;
    logic        mfault;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory returns 0 during reset, a junk word beyond its end.
    assign instr_in = !reset ? 32'h0 :
                      (pc_out[31:2] < 30'(WORDS)) ? mem[pc_out[11:2]] : 32'hBAD0_0BAD;

    function automatic item_t fetch_of(logic [31:0] a);
        item_t it;
        it.pc    = a;
        it.pc4   = a + 32'd4;
        it.instr = ((a >> 2) < WORDS) ? mem[a[11:2]] : NOP;
        return it;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: mirrors what the fetch stage is supposed to do each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            mpc    = RPC;
            mfault = 1'b0;
        end else if (redirect_valid) begin
            if (q.size() != 0) q.delete(0);          // wrong-path instruction dropped
            if (redirect_pc[1:0] != 2'b00) mfault = 1'b1;
            mpc = redirect_pc & ~32'd3;
        end else if (q.size() == 0) begin            // consumed item already popped
            q.push_back(fetch_of(mpc));
            if ((mpc >> 2) >= WORDS) mfault = 1'b1;
            mpc = mpc + 32'd4;
        end
    end

    // Monitor: compare DUT against the model between edges; pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            check("pc_out", pc_out, mpc);
            check("fetch_fault", 32'(fetch_fault), 32'(mfault));
            check("if_id_valid", 32'(if_id_valid), 32'(q.size() != 0));
            if (q.size() != 0 && if_id_valid) begin
                check("if_id_instr", if_id_instr, q[0].instr);
                check("if_id_pc", if_id_pc, q[0].pc);
                check("if_id_pc4", if_id_pc4, q[0].pc4);
                if (id_ready && !redirect_valid) q.delete(0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic redirect_to(logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[3] = 32'hD;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_pc", if_id_pc, RPC);
        check("rst_pc4", if_id_pc4, RPC + 32'd4);
        check("rst_fault", 32'(fetch_fault), 32'h0);
        check("rst_pc_out", pc_out, RPC);

        // Sequential fetch straight out of reset
        reset = 1'b1;
        tick(); check("seq_instr0", if_id_instr, 32'hA); check("seq_pc0", if_id_pc, 32'h0);
        tick(); check("seq_instr1", if_id_instr, 32'hB); check("seq_pc1", if_id_pc, 32'h4);
        tick(); check("seq_instr2", if_id_instr, 32'hC); check("seq_pc2", if_id_pc, 32'h8);

        // Stall three cycles, then resume with no duplicate
        id_ready = 1'b0;
        tick(); tick(); tick();
        check("stall_pc", if_id_pc, 32'h8);
        check("stall_pc_out", pc_out, 32'hC);
        check("stall_valid", 32'(if_id_valid), 32'h1);
        id_ready = 1'b1;
        tick();
        check("resume_instr", if_id_instr, 32'hD);
        check("resume_pc", if_id_pc, 32'hC);

        // Redirect while if_id_pc = 4
        do_reset();
        tick(); tick();
        check("pre_redir_pc", if_id_pc, 32'h4);
        redirect_to(32'h40);
        check("redir_bubble", 32'(if_id_valid), 32'h0);
        check("redir_pc_out", pc_out, 32'h40);
        tick();
        check("redir_if_id_pc", if_id_pc, 32'h40);

        // Misaligned redirect: aligned target, sticky fault
        redirect_to(32'h42);
        check("mis_pc_out", pc_out, 32'h40);
        check("mis_fault", 32'(fetch_fault), 32'h1);
        tick(); tick(); tick();
        check("mis_fault_sticky", 32'(fetch_fault), 32'h1);

        // Last valid word, then first out-of-range word
        do_reset();
        redirect_to(32'hFFC);
        tick();
        check("last_word_instr", if_id_instr, mem[WORDS-1]);
        check("last_word_fault", 32'(fetch_fault), 32'h0);
        tick();
        check("oor_pc", if_id_pc, 32'h1000);
        check("oor_instr", if_id_instr, NOP);
        check("oor_fault", 32'(fetch_fault), 32'h1);

        // PC wrap at the top of the address space
        do_reset();
        redirect_to(32'hFFFF_FFFC);
        tick();
        check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_pc_out", pc_out, 32'h0);

        // Reset mid-stall acts without a clock edge
        do_reset();
        tick(); tick();
        id_ready = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_valid", 32'(if_id_valid), 32'h0);
        check("async_pc_out", pc_out, RPC);
        check("async_fault", 32'(fetch_fault), 32'h0);

        // Reset overrides a concurrent redirect
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        check("rst_over_redir", pc_out, RPC);
        redirect_valid = 1'b0; id_ready = 1'b1;
        reset = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'($urandom_range(0, 255)) << 2;
                1:       t = (32'($urandom_range(0, WORDS-1)) << 2) | 32'($urandom_range(0, 3));
                2:       t = 32'hFE0 + 32'($urandom_range(0, 63));
                default: t = $urandom;
            endcase
            redirect_pc = t;
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
            tick();
        end
        redirect_valid = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
